rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter.sv | 111 +++++++++++
 tb/tb_rf_write_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// ============================================================================
//  Module   : rf_write_arbiter
//  Function : Two-requester register-file write arbiter with a one-entry stage,
//             R0 write suppression, read-port enables and read hazard flags.
//             Define RF_ARB_RR_EN for round-robin arbitration (default: fixed
//             priority, requester 0 wins).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_write_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [2:0]  req0_addr,
   input  logic [15:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [2:0]  req1_addr,
   input  logic [15:0] req1_data,
   output logic        req1_ready,
   input  logic        stall,
   output logic [7:0]  ld,
   output logic [15:0] Din,
   input  logic        rd_en,
   input  logic [2:0]  rdA_addr,
   input  logic [2:0]  rdB_addr,
   output logic [7:0]  oeA,
   output logic [7:0]  oeB,
   output logic        hazA,
   output logic        hazB
);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t      state;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        wr_valid;
   logic        grant0;
   logic        grant1;
   logic        can_accept;
   logic        hs0;
   logic        hs1;

   function automatic logic [7:0] onehot(input logic [2:0] a);
      onehot = 8'b0000_0001 << a;
   endfunction

   assign wr_valid = (state == FULL);

`ifdef RF_ARB_RR_EN
   // last_grant holds the index of the most recently accepted requester
   logic last_grant;

   assign grant0 = req0_valid & (~req1_valid | last_grant);
   assign grant1 = req1_valid & (~req0_valid | ~last_grant);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant <= 1'b1;
      end else if (hs0 | hs1) begin
         last_grant <= hs1;
      end
   end
`else
   assign grant0 = req0_valid;
   assign grant1 = req1_valid & ~req0_valid;
`endif

   assign can_accept = ~wr_valid | ~stall;
   assign req0_ready = grant0 & can_accept;
   assign req1_ready = grant1 & can_accept;
   assign hs0        = req0_valid & req0_ready;
   assign hs1        = req1_valid & req1_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= EMPTY;
         wr_addr <= 3'd0;
         wr_data <= 16'd0;
      end else begin
         if (hs0) begin
            state   <= FULL;
            wr_addr <= req0_addr;
            wr_data <= req0_data;
         end else if (hs1) begin
            state   <= FULL;
            wr_addr <= req1_addr;
            wr_data <= req1_data;
         end else if (wr_valid && !stall) begin
            state   <= EMPTY;
         end
      end
   end

   // R0 is hardwired zero: its writes are staged but never load
   assign ld  = (wr_valid && !stall && (wr_addr != 3'd0)) ? onehot(wr_addr) : 8'h00;
   assign Din = wr_data;

   assign oeA  = rd_en ? onehot(rdA_addr) : 8'h00;
   assign oeB  = rd_en ? onehot(rdB_addr) : 8'h00;
   assign hazA = rd_en & wr_valid & (wr_addr == rdA_addr) & (rdA_addr != 3'd0);
   assign hazB = rd_en & wr_valid & (wr_addr == rdB_addr) & (rdB_addr != 3'd0);

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
//  Module   : tb_rf_write_arbiter
//  Function : Scoreboard bench for rf_write_arbiter; expected register loads
//             are queued by the stimulus and retired by a load monitor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_write_arbiter;

   logic        clk;
   logic        reset;
   logic        req0_valid;
   logic [2:0]  req0_addr;
   logic [15:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [2:0]  req1_addr;
   logic [15:0] req1_data;
   logic        req1_ready;
   logic        stall;
   logic [7:0]  ld;
   logic [15:0] Din;
   logic        rd_en;
   logic [2:0]  rdA_addr;
   logic [2:0]  rdB_addr;
   logic [7:0]  oeA;
   logic [7:0]  oeB;
   logic        hazA;
   logic        hazB;

   typedef struct packed {
      logic [7:0]  ld;
      logic [15:0] din;
   } exp_t;

   exp_t exp_q[$];
   int   total;
   int   passed;

   rf_write_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .stall      (stall),
      .ld         (ld),
      .Din        (Din),
      .rd_en      (rd_en),
      .rdA_addr   (rdA_addr),
      .rdB_addr   (rdB_addr),
      .oeA        (oeA),
      .oeB        (oeB),
      .hazA       (hazA),
      .hazB       (hazB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] l, input logic [15:0] d);
      exp_t e;
      e.ld  = l;
      e.din = d;
      exp_q.push_back(e);
   endtask

   // Load monitor: every nonzero ld must match the oldest queued expectation
   always @(negedge clk) begin
      if (reset === 1'b1 && ld !== 8'h00) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_ld: got ld=0x%0h Din=0x%0h, expected no load (t=%0t)", ld, Din, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (ld === e.ld && Din === e.din) passed++;
            else $display("FAIL ld_din: got ld=0x%0h Din=0x%0h, expected ld=0x%0h Din=0x%0h (t=%0t)",
                          ld, Din, e.ld, e.din, $time);
         end
      end
   end

   initial begin
      reset = 1'b0; stall = 1'b0; rd_en = 1'b1;
      rdA_addr = 3'd3; rdB_addr = 3'd0;
      req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 16'hBEEF;
      req1_valid = 1'b0; req1_addr = 3'd0; req1_data = 16'h0000;
      #2;
      chk("reset_ld", {24'd0, ld}, 32'h0);
      chk("reset_din", {16'd0, Din}, 32'h0);
      chk("reset_hazA", {31'd0, hazA}, 32'h0);
      chk("reset_hazB", {31'd0, hazB}, 32'h0);
      chk("reset_ready0", {31'd0, req0_ready}, 32'h1);
      req0_valid = 1'b0;
      repeat (2) tick();
      reset = 1'b1;

      // Contention from reset: requester 0 wins first
      req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h1111;
      req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'h2222;
      #1;
      chk("cont_c1_ready0", {31'd0, req0_ready}, 32'h1);
      chk("cont_c1_ready1", {31'd0, req1_ready}, 32'h0);
      push(8'h02, 16'h1111);
      tick();
`ifdef RF_ARB_RR_EN
      req0_data = 16'h1112;
      #1;
      chk("cont_c2_ready0", {31'd0, req0_ready}, 32'h0);
      chk("cont_c2_ready1", {31'd0, req1_ready}, 32'h1);
      push(8'h04, 16'h2222);
      tick();
      req1_data = 16'h2223;
      #1;
      chk("cont_c3_ready0", {31'd0, req0_ready}, 32'h1);
      chk("cont_c3_ready1", {31'd0, req1_ready}, 32'h0);
      push(8'h02, 16'h1112);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("cont_c4_ready1", {31'd0, req1_ready}, 32'h1);
      push(8'h04, 16'h2223);
`else
      for (int k = 2; k <= 3; k++) begin
         req0_data = 16'h1110 + 16'(k);
         #1;
         chk("cont_fp_ready0", {31'd0, req0_ready}, 32'h1);
         chk("cont_fp_ready1", {31'd0, req1_ready}, 32'h0);
         push(8'h02, 16'h1110 + 16'(k));
         tick();
      end
      req0_valid = 1'b0;
      #1;
      chk("cont_c4_ready1", {31'd0, req1_ready}, 32'h1);
      push(8'h04, 16'h2222);
`endif
      tick();
      req1_valid = 1'b0;
      tick();

      // Single write to R3 with hazard / read enables
      req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 16'hBEEF;
      rdA_addr = 3'd3; rdB_addr = 3'd4;
      #1;
      chk("single_ready0", {31'd0, req0_ready}, 32'h1);
      push(8'h08, 16'hBEEF);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("single_hazA", {31'd0, hazA}, 32'h1);
      chk("single_hazB", {31'd0, hazB}, 32'h0);
      chk("single_oeA", {24'd0, oeA}, 32'h08);
      chk("single_oeB", {24'd0, oeB}, 32'h10);
      tick();
      #1;
      chk("drained_hazA", {31'd0, hazA}, 32'h0);

      // Stall: accepted while EMPTY even with stall high, then held 4 cycles
      req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 16'h5555;
      stall = 1'b1; rdA_addr = 3'd5; rdB_addr = 3'd5;
      #1;
      chk("stall_empty_ready0", {31'd0, req0_ready}, 32'h1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_addr = 3'd6; req1_data = 16'h6666;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("stall_ready0", {31'd0, req0_ready}, 32'h0);
         chk("stall_ready1", {31'd0, req1_ready}, 32'h0);
         chk("stall_hazA", {31'd0, hazA}, 32'h1);
         chk("stall_hazB", {31'd0, hazB}, 32'h1);
         chk("stall_oeA", {24'd0, oeA}, 32'h20);
         tick();
      end
      stall = 1'b0;
      #1;
      chk("unstall_ready1", {31'd0, req1_ready}, 32'h1);
      push(8'h20, 16'h5555);
      push(8'h40, 16'h6666);
      tick();
      req1_valid = 1'b0;
      tick();
      tick();

      // R0 write: accepted, staged, never loaded, no hazard
      req0_valid = 1'b1; req0_addr = 3'd0; req0_data = 16'hFFFF;
      rdA_addr = 3'd0;
      #1;
      chk("r0_ready0", {31'd0, req0_ready}, 32'h1);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("r0_hazA", {31'd0, hazA}, 32'h0);
      chk("r0_din", {16'd0, Din}, 32'hFFFF);
      tick();

      // Reset while FULL discards the staged write
      req0_valid = 1'b1; req0_addr = 3'd7; req0_data = 16'h7777;
      rdA_addr = 3'd7; stall = 1'b1;
      tick();
      req0_valid = 1'b0;
      #1;
      chk("prereset_hazA", {31'd0, hazA}, 32'h1);
      reset = 1'b0;
      #1;
      chk("midreset_hazA", {31'd0, hazA}, 32'h0);
      chk("midreset_ld", {24'd0, ld}, 32'h0);
      chk("midreset_din", {16'd0, Din}, 32'h0);
      stall = 1'b0;
      #1;
      chk("midreset_ld_unstall", {24'd0, ld}, 32'h0);
      tick();
      reset = 1'b1;
      req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'hAAAA;
      req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'hBBBB;
      #1;
      chk("postreset_ready0", {31'd0, req0_ready}, 32'h1);
      chk("postreset_ready1", {31'd0, req1_ready}, 32'h0);
      push(8'h02, 16'hAAAA);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("postreset_ready1_b", {31'd0, req1_ready}, 32'h1);
      push(8'h04, 16'hBBBB);
      tick();
      req1_valid = 1'b0;
      repeat (3) tick();

      chk("queue_drained", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
